// File: rtl/rst_seq_ctrl_if.sv
// Reset-sequencer request/status bundle.
// master: the side issuing warm-reset requests and observing status.
// slave:  the sequencer itself.
interface rst_seq_ctrl_if #(
  parameter int unsigned N_DOM = 3
) ();

  // Warm-reset requests (level, sampled every cycle)
  logic             sw_rst_req;
  logic             wdt_rst_req;

  // Sequencer status
  logic [N_DOM-1:0] dom_rst_n;
  logic             seq_busy;
  logic [1:0]       rst_cause;
  logic [7:0]       rst_cnt;

  modport master (
    output sw_rst_req,
    output wdt_rst_req,
    input  dom_rst_n,
    input  seq_busy,
    input  rst_cause,
    input  rst_cnt
  );

  modport slave (
    input  sw_rst_req,
    input  wdt_rst_req,
    output dom_rst_n,
    output seq_busy,
    output rst_cause,
    output rst_cnt
  );

endinterface

// File: rtl/rst_seq_ctrl.sv
// Central reset sequencer.
// Holds all domains in reset for HOLD_CYC cycles after the last reset event
// (global reset or warm request), then releases domain 0..N_DOM-1 in order,
// GAP_CYC cycles apart. Tracks the cause of the last reset and a saturating
// count of accepted warm resets. All outputs come straight from flops.
module rst_seq_ctrl #(
  parameter int unsigned N_DOM    = 3,
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned GAP_CYC  = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  rst_seq_ctrl_if.slave bus
);

  // idx must be able to hold N_DOM (value after the final release)
  localparam int unsigned IDX_W = $clog2(N_DOM + 1);

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_REL  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOM - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [N_DOM-1:0] dom_q,   dom_d;
  logic             busy_q,  busy_d;
  logic [1:0]       cause_q, cause_d;
  logic [7:0]       rcnt_q,  rcnt_d;
  logic             req_q,   req_d;

  logic             req_now;
  logic             req_new;

  assign req_now = bus.sw_rst_req | bus.wdt_rst_req;
  assign req_new = req_now & ~req_q;

  // Release sequencing: a request re-arms HOLD from any state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    busy_d  = busy_q;

    if (req_now) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            dom_d[0] = 1'b1;
            cnt_d    = '0;
            idx_d    = IDX_ONE;
            if (N_DOM == 1) begin
              state_d = ST_RUN;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_REL;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_REL: begin
          if (cnt_q == GAP_LAST) begin
            // Decoded loop instead of dom_d[idx_q] keeps the index width exact
            for (int unsigned k = 0; k < N_DOM; k++) begin
              if (idx_q == IDX_W'(k)) begin
                dom_d[k] = 1'b1;
              end
            end
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_RUN: begin
          dom_d  = '1;
          busy_d = 1'b0;
        end

        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          dom_d   = '0;
          busy_d  = 1'b1;
        end
      endcase
    end
  end

  // Cause/count bookkeeping on the rising edge of the combined request
  always_comb begin
    req_d   = req_now;
    cause_d = cause_q;
    rcnt_d  = rcnt_q;
    if (req_new) begin
      // Watchdog wins a tie with software
      cause_d = bus.wdt_rst_req ? 2'b10 : 2'b01;
      if (rcnt_q != 8'hFF) begin
        rcnt_d = rcnt_q + 8'd1;
      end
    end
  end

  // State registers; global reset overrides everything including requests
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      busy_q  <= 1'b1;
      cause_q <= 2'b00;
      rcnt_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      busy_q  <= busy_d;
      cause_q <= cause_d;
      rcnt_q  <= rcnt_d;
      req_q   <= req_d;
    end
  end

  assign bus.dom_rst_n = dom_q;
  assign bus.seq_busy  = busy_q;
  assign bus.rst_cause = cause_q;
  assign bus.rst_cnt   = rcnt_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: a timing-contract reference model feeds a
// scoreboard every cycle, a phase table checks end-of-phase states, and a
// second instance covers the N_DOM=1 / HOLD_CYC=1 corner configuration.
module tb_rst_seq_ctrl;

  localparam int unsigned N = 3;
  localparam int unsigned H = 16;
  localparam int unsigned G = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;

  always #5 clk = ~clk;

  rst_seq_ctrl_if #(.N_DOM(N)) bus  ();
  rst_seq_ctrl_if #(.N_DOM(1)) bus2 ();

  rst_seq_ctrl #(.N_DOM(N), .HOLD_CYC(H), .GAP_CYC(G), .CNT_W(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  rst_seq_ctrl #(.N_DOM(1), .HOLD_CYC(1), .GAP_CYC(4), .CNT_W(8)) dut2 (
    .clk_i  (clk),
    .rst_ni (rst2_n),
    .bus    (bus2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [2:0] dom;
    logic       busy;
    logic [1:0] cause;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: edges since the last reset event
  int unsigned m_since = 0;
  logic        m_reqd  = 1'b0;
  logic [1:0]  m_cause = 2'b00;
  logic [7:0]  m_cnt   = 8'd0;

  typedef struct {
    logic        r;
    logic        s;
    logic        w;
    int unsigned cyc;
    logic [2:0]  dom;
    logic        busy;
    logic [1:0]  cause;
    logic [7:0]  cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict, then compare after the edge
  task automatic step(input logic r, input logic s, input logic w);
    exp_t e;
    logic req;
    rst_n           = r;
    bus.sw_rst_req  = s;
    bus.wdt_rst_req = w;
    req = s | w;
    if (!r) begin
      m_since = 0;
      m_reqd  = 1'b0;
      m_cause = 2'b00;
      m_cnt   = 8'd0;
    end else begin
      if (req && !m_reqd) begin
        m_cause = w ? 2'b10 : 2'b01;
        if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      end
      if (req) m_since = 0;
      else if (m_since < 1000) m_since++;
      m_reqd = req;
    end
    for (int k = 0; k < 3; k++) e.dom[k] = (m_since >= H + k * G);
    e.busy  = !(m_since >= H + (N - 1) * G);
    e.cause = m_cause;
    e.cnt   = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("dom_rst_n", 32'(bus.dom_rst_n), 32'(e.dom));
    chk("seq_busy",  32'(bus.seq_busy),  32'(e.busy));
    chk("rst_cause", 32'(bus.rst_cause), 32'(e.cause));
    chk("rst_cnt",   32'(bus.rst_cnt),   32'(e.cnt));
  endtask

  // Single edge on the corner instance, checking its outputs afterwards
  task automatic step2(input logic r, input logic s, input logic w,
                       input logic dom, input logic busy,
                       input logic [1:0] cause, input logic [7:0] cnt);
    rst2_n           = r;
    bus2.sw_rst_req  = s;
    bus2.wdt_rst_req = w;
    @(posedge clk);
    #1;
    chk("c1_dom_rst_n", 32'(bus2.dom_rst_n), 32'(dom));
    chk("c1_seq_busy",  32'(bus2.seq_busy),  32'(busy));
    chk("c1_rst_cause", 32'(bus2.rst_cause), 32'(cause));
    chk("c1_rst_cnt",   32'(bus2.rst_cnt),   32'(cnt));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    //            r     s     w     cyc  dom     busy  cause  cnt
    tbl[0]  = '{1'b0, 1'b0, 1'b0,  5, 3'b000, 1'b1, 2'b00, 8'd0}; // power-on
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 15, 3'b000, 1'b1, 2'b00, 8'd0}; // L+15
    tbl[2]  = '{1'b1, 1'b0, 1'b0,  1, 3'b001, 1'b1, 2'b00, 8'd0}; // L+16
    tbl[3]  = '{1'b1, 1'b0, 1'b0,  4, 3'b011, 1'b1, 2'b00, 8'd0}; // L+20
    tbl[4]  = '{1'b1, 1'b0, 1'b0,  4, 3'b111, 1'b0, 2'b00, 8'd0}; // L+24
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 10, 3'b111, 1'b0, 2'b00, 8'd0}; // RUN
    tbl[6]  = '{1'b1, 1'b1, 1'b0,  1, 3'b000, 1'b1, 2'b01, 8'd1}; // sw pulse
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 16, 3'b001, 1'b1, 2'b01, 8'd1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0,  8, 3'b111, 1'b0, 2'b01, 8'd1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 10, 3'b000, 1'b1, 2'b10, 8'd2}; // both, held
    tbl[10] = '{1'b1, 1'b0, 1'b0, 15, 3'b000, 1'b1, 2'b10, 8'd2};
    tbl[11] = '{1'b1, 1'b0, 1'b0,  1, 3'b001, 1'b1, 2'b10, 8'd2};
    tbl[12] = '{1'b1, 1'b0, 1'b0,  2, 3'b001, 1'b1, 2'b10, 8'd2};
    tbl[13] = '{1'b1, 1'b0, 1'b1,  1, 3'b000, 1'b1, 2'b10, 8'd3}; // mid-REL wdt
    tbl[14] = '{1'b1, 1'b0, 1'b0, 24, 3'b111, 1'b0, 2'b10, 8'd3};
    tbl[15] = '{1'b1, 1'b1, 1'b0,  1, 3'b000, 1'b1, 2'b01, 8'd4};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 17, 3'b001, 1'b1, 2'b01, 8'd4}; // in REL
    tbl[17] = '{1'b0, 1'b0, 1'b0,  1, 3'b000, 1'b1, 2'b00, 8'd0}; // rst mid-REL
    tbl[18] = '{1'b0, 1'b1, 1'b1,  2, 3'b000, 1'b1, 2'b00, 8'd0}; // ignored reqs
    tbl[19] = '{1'b1, 1'b0, 1'b0, 24, 3'b111, 1'b0, 2'b00, 8'd0};
    tbl[20] = '{1'b1, 1'b1, 1'b0,  3, 3'b000, 1'b1, 2'b01, 8'd1}; // held sw
    tbl[21] = '{1'b1, 1'b0, 1'b0, 24, 3'b111, 1'b0, 2'b01, 8'd1};

    rst_n            = 1'b0;
    bus.sw_rst_req   = 1'b0;
    bus.wdt_rst_req  = 1'b0;
    rst2_n           = 1'b0;
    bus2.sw_rst_req  = 1'b0;
    bus2.wdt_rst_req = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      for (int unsigned c = 0; c < tbl[i].cyc; c++) begin
        step(tbl[i].r, tbl[i].s, tbl[i].w);
      end
      chk($sformatf("vec%0d_dom", i),   32'(bus.dom_rst_n), 32'(tbl[i].dom));
      chk($sformatf("vec%0d_busy", i),  32'(bus.seq_busy),  32'(tbl[i].busy));
      chk($sformatf("vec%0d_cause", i), 32'(bus.rst_cause), 32'(tbl[i].cause));
      chk($sformatf("vec%0d_cnt", i),   32'(bus.rst_cnt),   32'(tbl[i].cnt));
    end

    // Saturation: 260 separate pulses on top of the current count
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
    end
    chk("sat_cnt", 32'(bus.rst_cnt), 32'd255);
    step(1'b1, 1'b0, 1'b1);
    chk("sat_cnt_hold", 32'(bus.rst_cnt), 32'd255);
    chk("sat_cause_wdt", 32'(bus.rst_cause), 32'd2);

    // Corner configuration: N_DOM=1, HOLD_CYC=1
    step2(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 8'd0);
    step2(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 8'd0);
    step2(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 8'd1);
    step2(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 8'd1);
    step2(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 8'd2);
    step2(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 8'd2);
    step2(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 8'd2);
    step2(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 8'd2);
    step2(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
